duc_coef_load_ctrl: RTL and testbench

- Sequences reloading of the interpolation (DUC) coefficient table in the multi-rate processing chain.
- Takes a host load command plus a coefficient stream, then drives the DUC factor write port: clear pulse, then addressed writes.
- Mutes the datapath while the table is inconsistent.
- Commits the new 16-bit direction/ratio control word only after a successful load.
- Sits between the host register bank and the multi-rate processing system, in the clkin domain.

---
 rtl/duc_ctrl_pkg.sv | 21 ++
 rtl/duc_coef_load_timer.sv | 28 ++
 rtl/duc_coef_load_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_duc_coef_load_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/duc_ctrl_pkg.sv
// Shared types and defaults for the DUC coefficient-table load controller.
package duc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_SETTLE_CYCLES = 32;
  localparam int DEF_MAX_COEF      = 1024;
  localparam int TMR_W             = 16;

  function automatic logic count_legal(input logic [31:0] cnt, input logic [31:0] max_cnt);
    return (cnt != 32'd0) && (cnt <= max_cnt);
  endfunction

endpackage

// File: rtl/duc_coef_load_timer.sv
// Loadable down-counter; expire is high in the enabled cycle where the count is zero.
module duc_coef_load_timer #(
  parameter int W = 16
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count_r;

  assign expire = en && (count_r == {W{1'b0}});

  // Count register: load has priority, decrement parks at zero.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/duc_coef_load_ctrl.sv
// Sequences a DUC coefficient-table reload: clear, addressed writes, settle, then
// commit the direction/ratio control word. Aborts re-clear the table and flag err.
module duc_coef_load_ctrl
  import duc_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MAX_COEF      = DEF_MAX_COEF,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] coef_count,
  input  logic [15:0]       ctrl_word,
  input  logic              abort,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_ready,
  output logic [ADDR_W-1:0] duc_factor_wr_addr,
  output logic [DATA_W-1:0] duc_factor_wr_data,
  output logic              duc_factor_wr_en,
  output logic              duc_factor_wr_rst,
  output logic [15:0]       data_direction_ctrl,
  output logic              datapath_mute,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (longint'(MAX_COEF) >= (longint'(1) << ADDR_W)) begin : g_addr_range_chk
    $error("MAX_COEF must be smaller than 2**ADDR_W");
  end
  if ((RST_CYCLES < 1) || (SETTLE_CYCLES < 1)) begin : g_cycle_chk
    $error("RST_CYCLES and SETTLE_CYCLES must be at least 1");
  end

  localparam logic [TMR_W-1:0]  RST_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ONE_A       = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic [15:0]       ctrl_lat_r;
  logic              abort_flag_r;
  logic              coef_ready_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              wr_en_r;
  logic              wr_rst_r;
  logic [15:0]       ddc_r;
  logic              mute_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              start_ok_s;
  logic              hs_s;
  logic              last_hs_s;
  logic              timer_load_s;
  logic [TMR_W-1:0]  timer_val_s;
  logic              timer_en_s;
  logic              timer_exp_s;

  assign start_ok_s = start && count_legal(32'(coef_count), 32'(MAX_COEF));
  assign hs_s       = coef_valid && coef_ready_r && !abort;
  assign last_hs_s  = hs_s && (addr_cnt_r == (count_r - ONE_A));

  // Abort must veto a same-cycle handshake, so ready is the one output gated by an input.
  assign coef_ready          = coef_ready_r && !abort;
  assign duc_factor_wr_addr  = wr_addr_r;
  assign duc_factor_wr_data  = wr_data_r;
  assign duc_factor_wr_en    = wr_en_r;
  assign duc_factor_wr_rst   = wr_rst_r;
  assign data_direction_ctrl = ddc_r;
  assign datapath_mute       = mute_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign err                 = err_r;

  // Phase timer control: CLEAR and SETTLE count down, any abort restarts a clear.
  always_comb begin
    timer_load_s = 1'b0;
    timer_val_s  = RST_LOAD;
    timer_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) timer_load_s = 1'b1;
        else            timer_load_s = 1'b0;
      end
      ST_CLEAR, ST_SETTLE: begin
        if (abort) timer_load_s = 1'b1;
        else       timer_en_s   = 1'b1;
      end
      ST_LOAD: begin
        if (abort) begin
          timer_load_s = 1'b1;
        end else if (last_hs_s) begin
          timer_load_s = 1'b1;
          timer_val_s  = SETTLE_LOAD;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      default: timer_load_s = 1'b0;
    endcase
  end

  duc_coef_load_timer #(.W(TMR_W)) u_timer (
    .clkin    (clkin),
    .reset    (reset),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .en       (timer_en_s),
    .expire   (timer_exp_s)
  );

  // Load sequencer with registered write port and status outputs.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      count_r      <= {ADDR_W{1'b0}};
      addr_cnt_r   <= {ADDR_W{1'b0}};
      ctrl_lat_r   <= 16'h0000;
      abort_flag_r <= 1'b0;
      coef_ready_r <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_data_r    <= {DATA_W{1'b0}};
      wr_en_r      <= 1'b0;
      wr_rst_r     <= 1'b0;
      ddc_r        <= 16'h0000;
      mute_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && start_ok_s) begin
            count_r      <= coef_count;
            ctrl_lat_r   <= ctrl_word;
            err_r        <= 1'b0;
            abort_flag_r <= 1'b0;
            addr_cnt_r   <= {ADDR_W{1'b0}};
            wr_rst_r     <= 1'b1;
            mute_r       <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ST_CLEAR;
          end else if (start) begin
            err_r <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            abort_flag_r <= 1'b1;
            err_r        <= 1'b1;
          end else if (timer_exp_s) begin
            wr_rst_r <= 1'b0;
            if (abort_flag_r) begin
              abort_flag_r <= 1'b0;
              mute_r       <= 1'b0;
              busy_r       <= 1'b0;
              state_r      <= ST_IDLE;
            end else begin
              coef_ready_r <= 1'b1;
              state_r      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            abort_flag_r <= 1'b1;
            err_r        <= 1'b1;
            coef_ready_r <= 1'b0;
            addr_cnt_r   <= {ADDR_W{1'b0}};
            wr_rst_r     <= 1'b1;
            state_r      <= ST_CLEAR;
          end else if (hs_s) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= addr_cnt_r;
            wr_data_r  <= coef_data;
            addr_cnt_r <= addr_cnt_r + ONE_A;
            if (last_hs_s) begin
              coef_ready_r <= 1'b0;
              state_r      <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            abort_flag_r <= 1'b1;
            err_r        <= 1'b1;
            addr_cnt_r   <= {ADDR_W{1'b0}};
            wr_rst_r     <= 1'b1;
            state_r      <= ST_CLEAR;
          end else if (timer_exp_s) begin
            ddc_r   <= ctrl_lat_r;
            done_r  <= 1'b1;
            mute_r  <= 1'b0;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          coef_ready_r <= 1'b0;
          wr_rst_r     <= 1'b0;
          mute_r       <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duc_coef_load_ctrl.sv
// Scoreboard bench: the driver pushes expected writes/commits, a monitor pops and compares.
module tb_duc_coef_load_ctrl;

  localparam int ADDR_W = 16, DATA_W = 16, MAX_COEF = 1024;
  localparam int RST_CYCLES = 4, SETTLE_CYCLES = 32;

  logic              clkin = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] coef_count = '0;
  logic [15:0]       ctrl_word = '0;
  logic              abort = 1'b0;
  logic              coef_valid = 1'b0;
  logic [DATA_W-1:0] coef_data = '0;
  logic              coef_ready;
  logic [ADDR_W-1:0] duc_factor_wr_addr;
  logic [DATA_W-1:0] duc_factor_wr_data;
  logic              duc_factor_wr_en;
  logic              duc_factor_wr_rst;
  logic [15:0]       data_direction_ctrl;
  logic              datapath_mute;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clkin = ~clkin;

  duc_coef_load_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_COEF(MAX_COEF),
    .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clkin(clkin), .reset(reset), .start(start), .coef_count(coef_count),
    .ctrl_word(ctrl_word), .abort(abort), .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_ready(coef_ready), .duc_factor_wr_addr(duc_factor_wr_addr),
    .duc_factor_wr_data(duc_factor_wr_data), .duc_factor_wr_en(duc_factor_wr_en),
    .duc_factor_wr_rst(duc_factor_wr_rst), .data_direction_ctrl(data_direction_ctrl),
    .datapath_mute(datapath_mute), .busy(busy), .done(done), .err(err)
  );

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] done_q[$];

  int n_tests = 0, n_fail = 0;
  int rst_pulses = 0, exp_rst = 0, done_seen = 0, exp_done = 0;
  logic        err_m = 1'b0;
  logic [15:0] ddc_m = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int cyc = 0, rst_run = 0, last_wr = 0;
  always @(posedge clkin) begin
    #1;
    cyc++;
    if (!reset) begin
      rst_run = 0;
    end else begin
      if (duc_factor_wr_en) begin
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_extra: write addr %0h data %0h, expected no write",
                   duc_factor_wr_addr, duc_factor_wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(duc_factor_wr_addr), 32'(e.addr));
          check("wr_data", 32'(duc_factor_wr_data), 32'(e.data));
        end
      end
      if (duc_factor_wr_rst) begin
        rst_run++;
        check("mute_in_clear", 32'(datapath_mute), 32'd1);
      end else if (rst_run > 0) begin
        check("wr_rst_len", 32'(rst_run), 32'(RST_CYCLES));
        rst_pulses++;
        rst_run = 0;
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_extra: done pulse with ctrl %0h, expected none", data_direction_ctrl);
        end else begin
          check("done_ctrl", 32'(data_direction_ctrl), 32'(done_q.pop_front()));
          check("settle_len", 32'(cyc - last_wr), 32'(SETTLE_CYCLES));
          check("mute_at_done", 32'(datapath_mute), 32'd0);
        end
      end
      if (busy && !done) check("mute_busy", 32'(datapath_mute), 32'd1);
      if (!busy) check("mute_idle", 32'(datapath_mute), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},  32'(duc_factor_wr_en), 32'd0);
    check({tag, "_wr_rst"}, 32'(duc_factor_wr_rst), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_err"},    32'(err), 32'd0);
    check({tag, "_mute"},   32'(datapath_mute), 32'd0);
    check({tag, "_ready"},  32'(coef_ready), 32'd0);
    check({tag, "_ddc"},    32'(data_direction_ctrl), 32'd0);
    check({tag, "_addr"},   32'(duc_factor_wr_addr), 32'd0);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_err"},        32'(err), 32'(err_m));
    check({tag, "_ddc"},        32'(data_direction_ctrl), 32'(ddc_m));
    check({tag, "_rst_pulses"}, 32'(rst_pulses), 32'(exp_rst));
    check({tag, "_done_cnt"},   32'(done_seen), 32'(exp_done));
    check({tag, "_wr_left"},    32'(exp_q.size()), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic run_load(input int n, input logic [15:0] cw, input int gap_mode,
                          input int abort_after, input int busy_start_at,
                          input bit rst_settle, input int data_base);
    int  idx = 0, k = 0, w = 0;
    bit  aborted = 1'b0;
    bit  legal;
    legal = (n >= 1) && (n <= MAX_COEF);
    @(negedge clkin);
    start = 1'b1; coef_count = 16'(n); ctrl_word = cw;
    @(negedge clkin);
    start = 1'b0; ctrl_word = 16'h0000;
    if (!legal) begin
      err_m = 1'b1;
      repeat (3) @(negedge clkin);
      check("illegal_busy", 32'(busy), 32'd0);
      return;
    end
    err_m = 1'b0;
    exp_rst++;
    while (idx < n && !aborted) begin
      @(negedge clkin);
      k++;
      if (k > 20000) begin
        n_tests++; n_fail++;
        $display("FAIL load_timeout: %0d words accepted, expected %0d", idx, n);
        break;
      end
      case (gap_mode)
        0:       coef_valid = 1'b1;
        1:       coef_valid = k[0];
        default: coef_valid = ($urandom_range(0, 99) >= 30);
      endcase
      coef_data = (data_base >= 0) ? 16'(data_base + idx) : 16'($urandom);
      abort = (abort_after >= 0) && (idx == abort_after);
      start = (idx == busy_start_at);
      ctrl_word = start ? ~cw : 16'h0000;
      coef_count = start ? 16'd3 : coef_count;
      #1;
      if (abort) begin
        check("ready_on_abort", 32'(coef_ready), 32'd0);
        aborted = 1'b1;
        exp_rst++;
        err_m = 1'b1;
      end else if (coef_valid && coef_ready) begin
        exp_q.push_back('{addr: 16'(idx), data: coef_data});
        idx++;
      end
    end
    @(negedge clkin);
    abort = 1'b0; start = 1'b0; ctrl_word = 16'h0000;
    if (!aborted) begin
      ddc_m = cw;
      done_q.push_back(cw);
      exp_done++;
      coef_valid = 1'b1; coef_data = 16'hDEAD;
      #1 check("ready_after_last", 32'(coef_ready), 32'd0);
      repeat (3) @(negedge clkin);
    end
    coef_valid = 1'b0;
    if (rst_settle) begin
      repeat (8) @(negedge clkin);
      #2 reset = 1'b0;
      done_q.delete();
      exp_done--;
      ddc_m = 16'h0000;
      err_m = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge clkin);
      reset = 1'b1;
    end
    while (busy && w < 3000) begin
      @(negedge clkin);
      w++;
    end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=%0d after %0d cycles, expected 0", busy, w);
    end
    repeat (2) @(negedge clkin);
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (2) @(negedge clkin);

    run_load(8, 16'hA55A, 0, -1, -1, 1'b0, 32'h0100);
    end_checks("nominal");

    run_load(4, 16'h1234, 1, -1, -1, 1'b0, -1);
    end_checks("gapped");

    run_load(0, 16'h5555, 0, -1, -1, 1'b0, -1);
    end_checks("count0");
    run_load(1025, 16'h6666, 0, -1, -1, 1'b0, -1);
    end_checks("count1025");

    run_load(16, 16'hBEEF, 0, 5, -1, 1'b0, -1);
    end_checks("abort");

    run_load(6, 16'hC0DE, 0, -1, -1, 1'b1, -1);
    end_checks("rst_settle");
    run_load(5, 16'h0F0F, 2, -1, -1, 1'b0, -1);
    end_checks("after_rst");

    run_load(10, 16'h7E57, 0, -1, 2, 1'b0, -1);
    end_checks("busy_start");

    run_load(1, 16'h0001, 0, -1, -1, 1'b0, -1);
    end_checks("single");

    for (int t = 0; t < 4; t++) begin
      run_load(int'($urandom_range(1, 40)), 16'($urandom), 2, -1, -1, 1'b0, -1);
      end_checks("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
